// File: rtl/param_loader_pkg.sv
// Shared types and constants for the parameter-bank frame loader.
package param_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_SEL,
        GET_VAL,
        GET_CHK,
        COMMIT
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         SEL_W    = 3;
    localparam int         VAL_W    = 8;
    localparam int         N_PARAMS = 8;

    function automatic logic [7:0] frame_chk(input logic [SEL_W-1:0] sel,
                                             input logic [VAL_W-1:0] val);
        return HDR_BYTE ^ {{(8-SEL_W){1'b0}}, sel} ^ val;
    endfunction

endpackage

// File: rtl/param_loader_gap.sv
// Inter-byte gap counter; expired flags the cycle whose edge would reach the limit.
// Counter reaches the limit at most once before the owner leaves the frame, so it never wraps.
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/param_loader.sv
// Parses A5/SEL/VALUE/CHK frames and issues one-cycle program strobes to the bank.
// rx_ready drops only during the COMMIT cycle; all outputs are registered.
module param_loader
    import param_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [SEL_W-1:0] param_sel,
    output logic [VAL_W-1:0] param_value,
    output logic             param_program,
    output logic [N_PARAMS-1:0] programmed_mask,
    output logic [7:0]       err_count,
    output logic             busy
);

    state_t           state, next_state;
    logic             accept;
    logic             in_frame;
    logic             gap_expired;
    logic             timeout;
    logic             err_evt;
    logic [SEL_W-1:0] sel_q;
    logic [VAL_W-1:0] val_q;

    assign accept   = rx_valid && rx_ready;
    assign in_frame = (state == GET_SEL) || (state == GET_VAL) || (state == GET_CHK);
    // An accepted byte on the limit cycle clears the timer and beats the timeout.
    assign timeout  = gap_expired && !accept;

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || !in_frame),
        .en     (in_frame),
        .expired(gap_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        err_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && rx_data == HDR_BYTE) next_state = GET_SEL;
            end
            GET_SEL: begin
                if (accept) begin
                    if (rx_data[7:SEL_W] != '0) begin
                        err_evt    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = GET_VAL;
                    end
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            GET_VAL: begin
                if (accept) begin
                    next_state = GET_CHK;
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            GET_CHK: begin
                if (accept) begin
                    if (rx_data == frame_chk(sel_q, val_q)) begin
                        next_state = COMMIT;
                    end else begin
                        err_evt    = 1'b1;
                        next_state = IDLE;
                    end
                end else if (timeout) begin
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            val_q <= '0;
        end else begin
            if (accept && state == GET_SEL) sel_q <= rx_data[SEL_W-1:0];
            if (accept && state == GET_VAL) val_q <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready        <= 1'b1;
            busy            <= 1'b0;
            param_program   <= 1'b0;
            param_sel       <= '0;
            param_value     <= '0;
            programmed_mask <= '0;
            err_count       <= '0;
        end else begin
            rx_ready      <= (next_state != COMMIT);
            busy          <= (next_state != IDLE);
            param_program <= (state == COMMIT);
            if (state == COMMIT) begin
                param_sel   <= sel_q;
                param_value <= val_q;
            end
            // Mask follows the strobe by one cycle.
            if (param_program) programmed_mask[param_sel] <= 1'b1;
            if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// Directed frames against a byte-count reference model checked every cycle.
module tb_param_loader;

    localparam int T = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [2:0] param_sel;
    logic [7:0] param_value;
    logic       param_program;
    logic [7:0] programmed_mask;
    logic [7:0] err_count;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    logic [2:0] last_sel = 3'd0;
    logic [7:0] last_val = 8'd0;

    always #5 clk = ~clk;

    param_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .param_sel      (param_sel),
        .param_value    (param_value),
        .param_program  (param_program),
        .programmed_mask(programmed_mask),
        .err_count      (err_count),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts collected frame bytes instead of tracking states.
    int         m_n      = 0;
    int         m_gap    = 0;
    bit         m_commit = 1'b0;
    bit         m_acc;
    logic [2:0] m_fsel   = 3'd0;
    logic [7:0] m_fval   = 8'd0;
    logic       m_ready  = 1'b1;
    logic       m_busy   = 1'b0;
    logic       m_prog   = 1'b0;
    logic [2:0] m_sel    = 3'd0;
    logic [7:0] m_val    = 8'd0;
    logic [7:0] m_mask   = 8'd0;
    logic [7:0] m_err    = 8'd0;

    task automatic bump_err();
        if (m_err != 8'd255) m_err = m_err + 8'd1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_gap = 0; m_commit = 1'b0;
            m_ready = 1'b1; m_busy = 1'b0; m_prog = 1'b0;
            m_sel = 3'd0; m_val = 8'd0; m_mask = 8'd0; m_err = 8'd0;
        end else begin
            m_acc = rx_valid && m_ready;
            if (m_prog) begin
                m_mask[m_sel] = 1'b1;
                m_prog = 1'b0;
            end
            if (m_commit) begin
                m_commit = 1'b0;
                m_prog   = 1'b1;
                m_sel    = m_fsel;
                m_val    = m_fval;
                m_ready  = 1'b1;
            end else if (m_n == 0) begin
                if (m_acc && rx_data == 8'hA5) begin
                    m_n   = 1;
                    m_gap = 0;
                end
            end else if (m_acc) begin
                m_gap = 0;
                if (m_n == 1) begin
                    if (rx_data > 8'h07) begin
                        bump_err();
                        m_n = 0;
                    end else begin
                        m_fsel = rx_data[2:0];
                        m_n    = 2;
                    end
                end else if (m_n == 2) begin
                    m_fval = rx_data;
                    m_n    = 3;
                end else begin
                    if (rx_data == (8'hA5 ^ {5'b0, m_fsel} ^ m_fval)) begin
                        m_commit = 1'b1;
                        m_ready  = 1'b0;
                    end else begin
                        bump_err();
                    end
                    m_n = 0;
                end
            end else begin
                m_gap++;
                if (m_gap >= T) begin
                    bump_err();
                    m_n = 0;
                end
            end
            m_busy = (m_n != 0) || m_commit;
        end
    end

    always @(negedge clk) begin
        check("rx_ready", rx_ready, m_ready);
        check("busy", busy, m_busy);
        check("param_program", param_program, m_prog);
        check("param_sel", param_sel, m_sel);
        check("param_value", param_value, m_val);
        check("programmed_mask", programmed_mask, m_mask);
        check("err_count", err_count, m_err);
        if (param_program === 1'b1) begin
            n_strobe++;
            last_sel = param_sel;
            last_val = param_value;
        end
    end

    task automatic send(input logic [7:0] b);
        int  n;
        bit  acc_now;
        n       = 0;
        acc_now = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            @(negedge clk);
            acc_now = (rx_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end while (!acc_now && n < 20);
        if (!acc_now) check("send_accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] s, input logic [7:0] v, input logic [7:0] c);
        send(8'hA5); send(s); send(v); send(c);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rx_ready", rx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_program", param_program, 0);
        check("reset_sel", param_sel, 0);
        check("reset_value", param_value, 0);
        check("reset_mask", programmed_mask, 0);
        check("reset_err", err_count, 0);

        // Good frame, continuous valid
        frame(8'h03, 8'h7F, 8'hD9);
        idle(3);
        check("t1_strobes", n_strobe, 1);
        check("t1_sel", last_sel, 3);
        check("t1_val", last_val, 8'h7F);
        check("t1_mask", programmed_mask, 8'h08);
        check("t1_err", err_count, 0);

        // Bad checksum, then correct one
        frame(8'h02, 8'h10, 8'h00);
        idle(2);
        check("t2_err", err_count, 1);
        check("t2_model_err", m_err, 1);
        check("t2_idle", busy, 0);
        check("t2_no_strobe", n_strobe, 1);
        frame(8'h02, 8'h10, 8'hB7);
        idle(3);
        check("t2_strobes", n_strobe, 2);
        check("t2_sel", last_sel, 2);
        check("t2_val", last_val, 8'h10);
        check("t2_mask", programmed_mask, 8'h0C);

        // Out-of-range select, trailing bytes discarded
        send(8'hA5); send(8'h09);
        idle(1);
        check("t3_err", err_count, 2);
        check("t3_idle", busy, 0);
        send(8'h10); send(8'hB5);
        idle(2);
        check("t3_err_after_garbage", err_count, 2);
        check("t3_no_strobe", n_strobe, 2);

        // Timeout, then a byte arriving exactly on the limit cycle
        send(8'hA5);
        idle(T);
        check("t4_timeout_err", err_count, 3);
        check("t4_timeout_idle", busy, 0);
        send(8'hA5);
        idle(T - 1);
        send(8'h02); send(8'h10); send(8'hB7);
        idle(3);
        check("t4_late_err", err_count, 3);
        check("t4_late_strobes", n_strobe, 3);

        // Reset mid-frame
        send(8'hA5); send(8'h01);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_mask", programmed_mask, 0);
        check("t5_err", err_count, 0);
        check("t5_idle", busy, 0);
        frame(8'h01, 8'h20, 8'h84);
        idle(3);
        check("t5_strobes", n_strobe, 4);
        check("t5_sel", last_sel, 1);
        check("t5_val", last_val, 8'h20);
        check("t5_mask_after", programmed_mask, 8'h02);

        // Error counter saturation
        for (int i = 0; i < 300; i++) frame(8'h00, 8'h00, 8'h00);
        idle(2);
        check("t6_err_sat", err_count, 255);
        check("t6_model_sat", m_err, 255);
        send(8'h00); send(8'hFF);
        idle(2);
        check("t6_garbage", err_count, 255);

        // Back-to-back good frames
        frame(8'h04, 8'h55, 8'hF4);
        frame(8'h05, 8'h66, 8'hC6);
        idle(3);
        check("t7_strobes", n_strobe, 6);
        check("t7_sel", last_sel, 5);
        check("t7_val", last_val, 8'h66);
        check("t7_mask", programmed_mask, 8'h32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_loader.md
# param_loader

Frame-based programming controller for the robot's parameter bank. Consumes a byte stream from the UART receiver through a valid/ready handshake, validates 4-byte command frames, and issues one-cycle program strobes with select/value to the 8-entry parameter registers. Tracks which entries have been written and counts rejected frames for debug readout.

## Interface
- `TIMEOUT_CYCLES`, default 100000: max idle cycles between bytes inside a frame; minimum 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts byte; a byte transfers when `rx_valid && rx_ready`.
- `param_sel`  out  3  parameter index to the bank.
- `param_value`  out  8  value to write.
- `param_program`  out  1  one-cycle write strobe to the bank.
- `programmed_mask`  out  8  bit i set once entry i has been written since reset.
- `err_count`  out  8  rejected-frame count, saturating at 255.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Frame: `0xA5` header, SEL byte, VALUE byte, CHK byte; CHK = 0xA5 ^ SEL ^ VALUE.
- States: IDLE, GET_SEL, GET_VAL, GET_CHK, COMMIT.
- IDLE: accepted 0xA5 -> GET_SEL; any other accepted byte discarded, no error.
- GET_SEL: accepted byte with bits [7:3] nonzero -> error, IDLE; else latch SEL[2:0] -> GET_VAL.
- GET_VAL: latch VALUE -> GET_CHK.
- GET_CHK: CHK match -> COMMIT; mismatch -> error, IDLE.
- COMMIT: `param_program`=1 one cycle, `param_sel`/`param_value` = latched fields, set `programmed_mask[SEL]`; -> IDLE.
- `rx_ready` = 1 in every state except COMMIT.
- Error: `err_count` increments by 1, holds at 255.
- Timeout: in GET_SEL/GET_VAL/GET_CHK, gap counter increments each cycle without an accepted byte and clears on each accepted byte and on entering GET_SEL. When it reaches `TIMEOUT_CYCLES`, state -> IDLE, error counted. A byte accepted on the same cycle the limit would be reached wins: it is processed normally, no timeout.
- Rewriting an entry already in the mask is legal; mask bit stays 1.
- `param_sel`/`param_value` hold their last committed values between strobes.

## Timing
- Reset values: state IDLE, `rx_ready`=1, `param_sel`=0, `param_value`=0, `param_program`=0, `programmed_mask`=0, `err_count`=0, `busy`=0, gap counter 0.
- Reset mid-frame aborts the frame without counting an error; mask and counter clear.
- Latency: CHK accepted on edge N -> `param_program` high for the cycle after edge N+1, sel/value valid the same cycle; mask bit visible one cycle after the strobe.
- Back-to-back frames: next header accepted no earlier than the cycle after COMMIT. Minimum frame period is 5 cycles.
- Error/timeout return to IDLE and the `err_count` update take effect on the same edge.
- All outputs registered.

## Structure
- Package `param_loader_pkg`: state enum, `HDR_BYTE` = 8'hA5, `SEL_W` = 3, `VAL_W` = 8, `N_PARAMS` = 8.
- Sub-module `gap_timer`: clear/enable inputs and expired output; width `$clog2(TIMEOUT_CYCLES+1)`.
- Outputs connect directly to the parameter bank's select, value and program inputs.

## Test plan
- Bytes A5,03,7F,D9 with `rx_valid` continuous -> one `param_program` pulse with sel=3, value=0x7F; mask=0x08; err=0.
- A5,02,10,00 (bad CHK; correct is B7) -> no strobe, err=1, state IDLE; then A5,02,10,B7 -> strobe sel=2 value=0x10.
- A5,09 (SEL upper bits set) -> err=1, return to IDLE; the following 10,B5 bytes are discarded without error.
- With `TIMEOUT_CYCLES`=16: A5, then 16 idle cycles -> IDLE, err=1. Repeat with a byte arriving on cycle 16 -> no error, frame continues.
- Reset asserted after A5,01 -> mask=0, err=0, IDLE; a full frame A5,01,20,84 afterwards -> strobe sel=1 value=0x20.
- 300 bad-CHK frames -> `err_count` saturates at 255; garbage bytes in IDLE (e.g. 00,FF) never change err.
